// File: rtl/bsg_tag_stream_decoder_pkg.sv
// ---------------------------------------------------------------------------
// bsg_tag_stream_decoder_pkg
//
// Shared types and width helpers for the bsg_tag serial-stream decoder.
//   bsg_tag_decode_state_e : decoder FSM states (also exported as a debug port)
//   safe_clog2             : ceil(log2(n)), never less than 1
//   id_width_f             : node-id field width for a given client count
//   len_width_f            : length field width for a given maximum payload
//   max_f                  : larger of two widths
//
// The decoded-packet struct depends on the module parameters, so it is
// declared inside bsg_tag_stream_decoder (bsg_tag_decoded_pkt_s) using the
// helpers below for its field widths.
// ---------------------------------------------------------------------------
package bsg_tag_stream_decoder_pkg;

    typedef enum logic [2:0] {
        BSG_TAG_IDLE    = 3'd0,
        BSG_TAG_LEN     = 3'd1,
        BSG_TAG_DNR     = 3'd2,
        BSG_TAG_ID      = 3'd3,
        BSG_TAG_PAYLOAD = 3'd4,
        BSG_TAG_SKIP    = 3'd5
    } bsg_tag_decode_state_e;

    // Smallest r with 2**r >= n, clamped to 1 so a field is never zero wide.
    function automatic int safe_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int id_width_f(input int els);
        return safe_clog2(els);
    endfunction

    // The length field must be able to encode max_payload itself.
    function automatic int len_width_f(input int max_payload);
        return safe_clog2(max_payload + 1);
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_tag_stream_decoder_shift.sv
// ---------------------------------------------------------------------------
// bsg_tag_stream_decoder_shift
//
// LSB-first serial-in register with indexed write and synchronous clear.
// Each field of a tag packet arrives one bit per qualified cycle; the bit at
// index idx_i is written into position idx_i, so bit k of the field lands in
// bit k of the register regardless of how long the stream pauses.
//
// data_o is write-through: it shows the stored value with this cycle's write
// already applied. That lets the parent capture a complete field on the very
// edge that samples its final bit.
//
// Ports:
//   clk_i      in   1            clock
//   reset_n_i  in   1            asynchronous active-low reset
//   clear_i    in   1            zero the register on the next edge
//   we_i       in   1            write bit_i at index idx_i on the next edge
//   idx_i      in   idx_width_p  bit position to write
//   bit_i      in   1            serial data bit
//   data_o     out  width_p      register contents including this cycle's write
// ---------------------------------------------------------------------------
module bsg_tag_stream_decoder_shift #(
    parameter int width_p     = 1,
    parameter int idx_width_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    input  logic                   we_i,
    input  logic [idx_width_p-1:0] idx_i,
    input  logic                   bit_i,
    output logic [width_p-1:0]     data_o
);

    logic [width_p-1:0] data_r;
    logic [width_p-1:0] data_n;

    always_comb begin
        data_n = data_r;
        if (clear_i) begin
            data_n = '0;
        end
        for (int i = 0; i < width_p; i++) begin
            if (we_i && (idx_i == i[idx_width_p-1:0])) begin
                data_n[i] = bit_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r <= '0;
        end else begin
            data_r <= data_n;
        end
    end

    assign data_o = data_n;

endmodule

// File: rtl/bsg_tag_stream_decoder.sv
// ---------------------------------------------------------------------------
// bsg_tag_stream_decoder
//
// Receive end of the bsg_tag serial protocol. Deserializes the bit-serial
// stream on data_i (qualified by en_i) into node id, data_not_reset flag,
// length and payload, and presents each packet in a one-entry output
// register.
//
// Wire format, first bit first:
//   '1' start | len (LSB first) | data_not_reset | node id (LSB first) |
//   payload (len bits, LSB first)
//
// Configuration macro:
//   BSG_TAG_STREAM_DECODER_NODE_FILTER_EN
//     defined   : packets whose node id differs from node_id_p are dropped
//                 silently (no v_o, no overflow_o).
//     undefined : every well-formed packet is emitted; node_id_p has no effect.
//
// Ports:
//   clk_i             in   1          tag clock, posedge sampling
//   reset_n_i         in   1          asynchronous active-low reset
//   en_i              in   1          stream qualifier; en_i=0 pauses decoding
//   data_i            in   1          serial tag bit
//   v_o               out  1          decoded packet valid
//   node_id_o         out  id width   packet node id
//   data_not_reset_o  out  1          packet data_not_reset flag
//   len_o             out  len width  payload length in bits
//   payload_o         out  max width  payload, right-justified, upper bits zero
//   yumi_i            in   1          consumer takes the packet
//   overflow_o        out  1          sticky: packet arrived while register full
//   len_err_o         out  1          sticky: length field above maximum
//   state_o           out  3          current decoder state (debug)
//
// Handshake: v_o/yumi_i is a valid/yumi pair. v_o stays high and the data
// outputs stay stable until the consumer raises yumi_i, which is only legal
// while v_o=1; the entry is released on the edge where yumi_i=1. A packet
// completing on that same edge refills the entry, so v_o then stays high.
// ---------------------------------------------------------------------------
module bsg_tag_stream_decoder
    import bsg_tag_stream_decoder_pkg::*;
#(
    // No meaningful defaults: both must be set by the instantiating design.
    parameter int els_p               = 1,
    parameter int max_payload_width_p = 1,
    parameter int node_id_p           = 0
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic                                          en_i,
    input  logic                                          data_i,
    output logic                                          v_o,
    output logic [id_width_f(els_p)-1:0]                  node_id_o,
    output logic                                          data_not_reset_o,
    output logic [len_width_f(max_payload_width_p)-1:0]   len_o,
    output logic [max_payload_width_p-1:0]                payload_o,
    input  logic                                          yumi_i,
    output logic                                          overflow_o,
    output logic                                          len_err_o,
    output bsg_tag_decode_state_e                         state_o
);

    localparam int id_w_lp  = id_width_f(els_p);
    localparam int len_w_lp = len_width_f(max_payload_width_p);
    // One counter walks every field, so it must reach the widest index:
    // len_w-1 in LEN, id_w-1 in ID, and up to 2**len_w-1 in SKIP.
    localparam int cnt_w_lp = max_f(len_w_lp, id_w_lp);

    localparam logic [cnt_w_lp-1:0] len_last_lp = cnt_w_lp'(len_w_lp - 1);
    localparam logic [cnt_w_lp-1:0] id_last_lp  = cnt_w_lp'(id_w_lp - 1);
    localparam logic [len_w_lp-1:0] max_len_lp  = len_w_lp'(max_payload_width_p);
    localparam logic [id_w_lp-1:0]  node_id_lp  = id_w_lp'(node_id_p);

`ifdef BSG_TAG_STREAM_DECODER_NODE_FILTER_EN
    localparam bit filter_en_lp = 1'b1;
`else
    localparam bit filter_en_lp = 1'b0;
`endif

    typedef struct packed {
        logic [id_w_lp-1:0]             id;
        logic                           dnr;
        logic [len_w_lp-1:0]            len;
        logic [max_payload_width_p-1:0] payload;
    } bsg_tag_decoded_pkt_s;

    bsg_tag_decode_state_e state_r;
    logic [cnt_w_lp-1:0]   cnt_r;
    logic                  dnr_r;
    logic                  v_r;
    logic                  overflow_r;
    logic                  len_err_r;
    bsg_tag_decoded_pkt_s  pkt_r;
    bsg_tag_decoded_pkt_s  pkt_n;

    logic                           field_clear;
    logic                           len_we;
    logic                           id_we;
    logic                           pay_we;
    logic                           complete;
    logic                           keep;
    logic                           emit;
    logic [len_w_lp-1:0]            len_q;
    logic [id_w_lp-1:0]             id_q;
    logic [max_payload_width_p-1:0] pay_q;
    logic [cnt_w_lp-1:0]            len_end;

    // ------------------------------------------------------------------
    // Field registers. All three are cleared by the start bit so payload
    // bits at and above len read back as zero.
    // ------------------------------------------------------------------
    bsg_tag_stream_decoder_shift #(
        .width_p     (len_w_lp),
        .idx_width_p (cnt_w_lp)
    ) len_shift (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (field_clear),
        .we_i      (len_we),
        .idx_i     (cnt_r),
        .bit_i     (data_i),
        .data_o    (len_q)
    );

    bsg_tag_stream_decoder_shift #(
        .width_p     (id_w_lp),
        .idx_width_p (cnt_w_lp)
    ) id_shift (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (field_clear),
        .we_i      (id_we),
        .idx_i     (cnt_r),
        .bit_i     (data_i),
        .data_o    (id_q)
    );

    bsg_tag_stream_decoder_shift #(
        .width_p     (max_payload_width_p),
        .idx_width_p (cnt_w_lp)
    ) payload_shift (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (field_clear),
        .we_i      (pay_we),
        .idx_i     (cnt_r),
        .bit_i     (data_i),
        .data_o    (pay_q)
    );

    // Index of the last payload (or skipped) bit. Only used when len > 0.
    assign len_end = cnt_w_lp'(len_q) - cnt_w_lp'(1);

    // ------------------------------------------------------------------
    // Per-cycle strobes. Everything is gated by en_i so a pause freezes
    // both the FSM and the field registers.
    // ------------------------------------------------------------------
    always_comb begin
        field_clear = 1'b0;
        len_we      = 1'b0;
        id_we       = 1'b0;
        pay_we      = 1'b0;
        complete    = 1'b0;
        if (en_i) begin
            case (state_r)
                BSG_TAG_IDLE:    field_clear = data_i;
                BSG_TAG_LEN:     len_we      = 1'b1;
                BSG_TAG_ID: begin
                    id_we    = 1'b1;
                    complete = (cnt_r == id_last_lp) && (len_q == '0);
                end
                BSG_TAG_PAYLOAD: begin
                    pay_we   = 1'b1;
                    complete = (cnt_r == len_end);
                end
                default: ;
            endcase
        end
    end

    // id_q and pay_q are write-through, so they already hold the bit being
    // sampled on the completing edge.
    assign keep  = !filter_en_lp || (id_q == node_id_lp);
    assign emit  = complete && keep;

    always_comb begin
        pkt_n         = '0;
        pkt_n.id      = id_q;
        pkt_n.dnr     = dnr_r;
        pkt_n.len     = len_q;
        pkt_n.payload = pay_q;
    end

    // ------------------------------------------------------------------
    // FSM, bit counter, output register and sticky flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= BSG_TAG_IDLE;
            cnt_r      <= '0;
            dnr_r      <= 1'b0;
            v_r        <= 1'b0;
            pkt_r      <= '0;
            overflow_r <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            // Output entry: refill wins over release on the same edge; a
            // packet arriving while the entry is held is dropped.
            if (emit) begin
                if (!v_r || yumi_i) begin
                    v_r   <= 1'b1;
                    pkt_r <= pkt_n;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else if (yumi_i) begin
                v_r <= 1'b0;
            end

            if (en_i) begin
                case (state_r)
                    BSG_TAG_IDLE: begin
                        if (data_i) begin
                            state_r <= BSG_TAG_LEN;
                            cnt_r   <= '0;
                        end
                    end
                    BSG_TAG_LEN: begin
                        if (cnt_r == len_last_lp) begin
                            state_r <= BSG_TAG_DNR;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                    BSG_TAG_DNR: begin
                        dnr_r   <= data_i;
                        state_r <= BSG_TAG_ID;
                        cnt_r   <= '0;
                    end
                    BSG_TAG_ID: begin
                        if (cnt_r == id_last_lp) begin
                            cnt_r <= '0;
                            if (len_q == '0) begin
                                state_r <= BSG_TAG_IDLE;
                            end else if (len_q > max_len_lp) begin
                                state_r   <= BSG_TAG_SKIP;
                                len_err_r <= 1'b1;
                            end else begin
                                state_r <= BSG_TAG_PAYLOAD;
                            end
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                    BSG_TAG_PAYLOAD, BSG_TAG_SKIP: begin
                        // SKIP walks the same len bits but never completes.
                        if (cnt_r == len_end) begin
                            state_r <= BSG_TAG_IDLE;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                    default: begin
                        state_r <= BSG_TAG_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign v_o              = v_r;
    assign node_id_o        = pkt_r.id;
    assign data_not_reset_o = pkt_r.dnr;
    assign len_o            = pkt_r.len;
    assign payload_o        = pkt_r.payload;
    assign overflow_o       = overflow_r;
    assign len_err_o        = len_err_r;
    assign state_o          = state_r;

endmodule

// File: tb/tb_bsg_tag_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_bsg_tag_stream_decoder
//
// Bench for bsg_tag_stream_decoder with els_p=4 (2-bit id), max payload 8
// (4-bit length field), node_id_p=1. Packets are built as bit lists from
// (len, dnr, id, payload) and the expected output register / sticky flags
// come from a packet-level model of the decoder's rules.
// ---------------------------------------------------------------------------
module tb_bsg_tag_stream_decoder;
    import bsg_tag_stream_decoder_pkg::*;

    localparam int els_lp     = 4;
    localparam int max_lp     = 8;
    localparam int node_id_lp = 1;
    localparam int len_w_lp   = 4;
    localparam int id_w_lp    = 2;
    // Bit index (in the packet list) of the last node-id bit.
    localparam int last_id_bit_lp = 1 + len_w_lp + 1 + id_w_lp - 1;

`ifdef BSG_TAG_STREAM_DECODER_NODE_FILTER_EN
    localparam bit filter_en_lp = 1'b1;
`else
    localparam bit filter_en_lp = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    logic en;
    logic data;
    logic yumi;
    logic v;
    logic [id_w_lp-1:0]  node_id;
    logic dnr_out;
    logic [len_w_lp-1:0] len_out;
    logic [max_lp-1:0]   payload;
    logic overflow;
    logic len_err;
    bsg_tag_decode_state_e state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bsg_tag_stream_decoder #(
        .els_p               (els_lp),
        .max_payload_width_p (max_lp),
        .node_id_p           (node_id_lp)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .en_i             (en),
        .data_i           (data),
        .v_o              (v),
        .node_id_o        (node_id),
        .data_not_reset_o (dnr_out),
        .len_o            (len_out),
        .payload_o        (payload),
        .yumi_i           (yumi),
        .overflow_o       (overflow),
        .len_err_o        (len_err),
        .state_o          (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    bit exp_v;
    int exp_id;
    bit exp_dnr;
    int exp_len;
    int exp_pay;
    bit exp_ovf;
    bit exp_lerr;

    task automatic model_reset();
        exp_v = 0; exp_id = 0; exp_dnr = 0; exp_len = 0; exp_pay = 0;
        exp_ovf = 0; exp_lerr = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_v"},        32'(v),        32'(exp_v));
        chk({tag, "_id"},       32'(node_id),  32'(exp_id));
        chk({tag, "_dnr"},      32'(dnr_out),  32'(exp_dnr));
        chk({tag, "_len"},      32'(len_out),  32'(exp_len));
        chk({tag, "_payload"},  32'(payload),  32'(exp_pay));
        chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_len_err"},  32'(len_err),  32'(exp_lerr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release the output entry (only called while the model says it is full).
    task automatic do_yumi();
        en   = 1'b0;
        yumi = 1'b1;
        tick();
        yumi  = 1'b0;
        exp_v = 0;
        chk("yumi_release_v", 32'(v), 32'(exp_v));
    endtask

    // Send one packet. pause_n idle (en=0) cycles are inserted before list
    // bit pause_at; yumi_last raises yumi_i on the cycle of the final bit.
    task automatic send_pkt(input int len, input bit pdnr, input int id, input int pay,
                            input int pause_at, input int pause_n, input bit yumi_last);
        bit bits[$];
        int n;
        bit completes;
        bit kept;
        bits.push_back(1'b1);
        for (int i = 0; i < len_w_lp; i++) bits.push_back(len[i]);
        bits.push_back(pdnr);
        for (int i = 0; i < id_w_lp; i++) bits.push_back(id[i]);
        for (int i = 0; i < len; i++) begin
            if (len <= max_lp) bits.push_back(pay[i]);
            else               bits.push_back(1'($urandom_range(0, 1)));
        end
        n = bits.size();
        for (int k = 0; k < n; k++) begin
            if (k == pause_at) begin
                for (int p = 0; p < pause_n; p++) begin
                    en   = 1'b0;
                    data = 1'($urandom_range(0, 1));
                    tick();
                    chk("pause_v", 32'(v), 32'(exp_v));
                end
            end
            en   = 1'b1;
            data = bits[k];
            yumi = (k == n - 1) ? yumi_last : 1'b0;
            tick();
            if (k == last_id_bit_lp && len > max_lp) exp_lerr = 1;
            if (k == n - 1) begin
                completes = (len <= max_lp);
                kept      = !filter_en_lp || (id == node_id_lp);
                if (completes && kept) begin
                    if (!exp_v || yumi_last) begin
                        exp_v   = 1;
                        exp_id  = id;
                        exp_dnr = pdnr;
                        exp_len = len;
                        exp_pay = pay & ((1 << len) - 1);
                    end else begin
                        exp_ovf = 1;
                    end
                end else if (yumi_last) begin
                    exp_v = 0;
                end
            end
            chk("bit_v",        32'(v),        32'(exp_v));
            chk("bit_overflow", 32'(overflow), 32'(exp_ovf));
            chk("bit_len_err",  32'(len_err),  32'(exp_lerr));
        end
        en   = 1'b0;
        yumi = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    int  r_len;
    int  r_id;
    int  r_pay;
    int  r_pa;
    bit  r_dnr;
    bit  r_yl;

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        data    = 1'b0;
        yumi    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_state", 32'(state_dbg), 32'(BSG_TAG_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic packet: len=5 dnr=1 id=2 payload 5'b10110.
        send_pkt(5, 1'b1, 2, 32'h16, -1, 0, 1'b0);
        check_all("basic");
        chk("basic_payload_const", 32'(payload), 32'h16);
        do_yumi();

        // Same packet with a 3-cycle pause inside the payload.
        send_pkt(5, 1'b1, 2, 32'h16, 10, 3, 1'b0);
        check_all("paused");

        // Back-to-back while full: second packet dropped, overflow raised.
        send_pkt(3, 1'b0, 1, 32'h5, -1, 0, 1'b0);
        check_all("overflow");

        // Oversized length is skipped; a following packet still decodes.
        do_yumi();
        send_pkt(12, 1'b1, 2, 32'h0, -1, 0, 1'b0);
        check_all("len_err");
        send_pkt(3, 1'b0, 1, 32'h5, -1, 0, 1'b0);
        check_all("after_skip");

        // Zero-length packet completes on the last id bit.
        do_yumi();
        send_pkt(0, 1'b0, 3, 32'h0, -1, 0, 1'b0);
        check_all("len_zero");

        // Completion on the same edge as yumi refills the entry.
        send_pkt(4, 1'b1, 0, 32'h9, -1, 0, 1'b1);
        check_all("yumi_refill");

        // Reset in the middle of the length field; stream bits held high
        // while reset is active must not start a packet.
        en = 1'b1; data = 1'b1; tick();
        data = 1'b1; tick();
        data = 1'b0; tick();
        #2;
        reset_n = 1'b0;
        data    = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        en      = 1'b0;
        tick();
        check_all("post_reset");
        send_pkt(7, 1'b1, 2, 32'h5a, -1, 0, 1'b0);
        check_all("reset_recover");

        // Node filtering: id 3 then id 1 (both emitted when filtering is off).
        do_yumi();
        send_pkt(2, 1'b1, 3, 32'h2, -1, 0, 1'b0);
        check_all("filter_other");
        if (exp_v) do_yumi();
        send_pkt(2, 1'b0, 1, 32'h1, -1, 0, 1'b0);
        check_all("filter_match");

        // Randomized packets: lengths including oversize, pauses, and
        // random release / same-edge release of the output entry.
        for (int r = 0; r < 40; r++) begin
            r_len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(9, 15))
                                                : int'($urandom_range(0, max_lp));
            r_id  = int'($urandom_range(0, els_lp - 1));
            r_pay = int'($urandom_range(0, 255));
            r_dnr = 1'($urandom_range(0, 1));
            if (exp_v && $urandom_range(0, 2) != 0) do_yumi();
            r_yl  = exp_v && ($urandom_range(0, 3) == 0);
            r_pa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7 + r_len)) : -1;
            send_pkt(r_len, r_dnr, r_id, r_pay, r_pa, int'($urandom_range(1, 3)), r_yl);
            check_all("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
